// File: rtl/div_iterative_core.sv
// rtl/div_iterative_core.sv - radix-2 restoring divider, RISC-V M DIV/DIVU/REM/REMU semantics
// Optional build macro MDU_DIV_ZERO_BYPASS_EN: zero divisor skips the CALC iterations.
module div_iterative_core #(
   parameter int PAR          = 32,
   parameter int OPCODE_WIDTH = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [OPCODE_WIDTH-1:0] opCode,
   input  logic [PAR:0]            dividend,
   input  logic [PAR:0]            divisor,
   output logic                    busy,
   output logic                    done,
   output logic [PAR-1:0]          result
);

   localparam int CNT_W = (PAR > 1) ? $clog2(PAR) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAR - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state_q;
   logic             busy_q;
   logic             done_q;
   logic [PAR-1:0]   result_q;
   logic             rem_sel_q;
   logic             sd_q;
   logic             sv_q;
   logic [PAR-1:0]   dvd_mag_q;
   logic [PAR-1:0]   dvs_mag_q;
   logic [PAR-1:0]   rem_q;
   logic [PAR-1:0]   quo_q;
   logic [CNT_W-1:0] cnt_q;

   logic [PAR-1:0]   dvd_mag_d;
   logic [PAR-1:0]   dvs_mag_d;
   logic [PAR:0]     rem_shift;
   logic [PAR:0]     trial;
   logic [PAR-1:0]   step_rem_d;
   logic [PAR-1:0]   step_quo_d;
   logic [PAR-1:0]   quo_fix;
   logic [PAR-1:0]   rem_fix;
   logic [PAR-1:0]   fix_result_d;
   logic             unused_opcode_bits;

   assign unused_opcode_bits = ^{opCode[OPCODE_WIDTH-1:2], opCode[0]};

   // Bit PAR alone carries the sign: unsigned operands arrive zero-extended.
   // Negating the low PAR bits equals the low PAR bits of the full negation.
   always_comb begin
      dvd_mag_d = dividend[PAR] ? -dividend[PAR-1:0] : dividend[PAR-1:0];
      dvs_mag_d = divisor[PAR]  ? -divisor[PAR-1:0]  : divisor[PAR-1:0];
   end

   always_comb begin
      rem_shift  = {rem_q, quo_q[PAR-1]};
      trial      = rem_shift - {1'b0, dvs_mag_q};
      step_rem_d = rem_shift[PAR-1:0];
      step_quo_d = {quo_q[PAR-2:0], 1'b0};
      if (!trial[PAR]) begin
         step_rem_d = trial[PAR-1:0];
         step_quo_d = {quo_q[PAR-2:0], 1'b1};
      end
   end

   // Signed overflow falls out naturally: magnitude 2^(PAR-1) truncates to itself.
   always_comb begin
      quo_fix = (sd_q ^ sv_q) ? -quo_q : quo_q;
      rem_fix = sd_q ? -rem_q : rem_q;
      if (dvs_mag_q == '0) begin
         quo_fix = '1;
         rem_fix = sd_q ? -dvd_mag_q : dvd_mag_q;
      end
      fix_result_d = rem_sel_q ? rem_fix : quo_fix;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= '0;
         rem_sel_q <= 1'b0;
         sd_q      <= 1'b0;
         sv_q      <= 1'b0;
         dvd_mag_q <= '0;
         dvs_mag_q <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         cnt_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  rem_sel_q <= opCode[1];
                  sd_q      <= dividend[PAR];
                  sv_q      <= divisor[PAR];
                  dvd_mag_q <= dvd_mag_d;
                  dvs_mag_q <= dvs_mag_d;
                  quo_q     <= dvd_mag_d;
                  rem_q     <= '0;
                  cnt_q     <= '0;
                  busy_q    <= 1'b1;
`ifdef MDU_DIV_ZERO_BYPASS_EN
                  state_q   <= (dvs_mag_d == '0) ? S_FIX : S_CALC;
`else
                  state_q   <= S_CALC;
`endif
               end
            end
            S_CALC: begin
               rem_q <= step_rem_d;
               quo_q <= step_quo_d;
               cnt_q <= cnt_q + CNT_ONE;
               if (cnt_q == CNT_LAST) begin
                  state_q <= S_FIX;
               end
            end
            S_FIX: begin
               result_q <= fix_result_d;
               busy_q   <= 1'b0;
               done_q   <= 1'b1;
               state_q  <= S_DONE;
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_div_iterative_core.sv
// tb/tb_div_iterative_core.sv - scoreboard bench for div_iterative_core
// Expected latency follows MDU_DIV_ZERO_BYPASS_EN when defined.
module tb_div_iterative_core;

   localparam int PAR = 32;
   localparam int LAT = 33;
`ifdef MDU_DIV_ZERO_BYPASS_EN
   localparam int ZLAT = 1;
`else
   localparam int ZLAT = 33;
`endif

   localparam logic [2:0] OP_DIV  = 3'b100;
   localparam logic [2:0] OP_DIVU = 3'b101;
   localparam logic [2:0] OP_REM  = 3'b110;
   localparam logic [2:0] OP_REMU = 3'b111;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic [2:0]     opCode = '0;
   logic [PAR:0]   dividend = '0;
   logic [PAR:0]   divisor = '0;
   logic           busy;
   logic           done;
   logic [PAR-1:0] result;

   div_iterative_core #(.PAR(PAR), .OPCODE_WIDTH(3)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .opCode(opCode),
      .dividend(dividend),
      .divisor(divisor),
      .busy(busy),
      .done(done),
      .result(result)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   typedef struct {
      logic [PAR-1:0] res;
      int             at;
      string          name;
   } exp_t;

   exp_t sb[$];
   int vectors = 0;
   int miscompares = 0;
   int done_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors = vectors + 1;
      if (act !== req) begin
         miscompares = miscompares + 1;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && done) begin
         done_cnt = done_cnt + 1;
         if (sb.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            check({e.name, "_result"}, 64'(result), 64'(e.res));
            check({e.name, "_cycle"}, 64'(cyc), 64'(e.at));
            check({e.name, "_busy"}, 64'(busy), 64'd0);
         end
      end
   end

   task automatic issue(input logic [2:0] op, input logic [PAR:0] dvd, input logic [PAR:0] dvs,
                        input logic [PAR-1:0] res, input bit zero, input string name,
                        output int acc);
      exp_t e;
      @(negedge clk);
      opCode = op;
      dividend = dvd;
      divisor = dvs;
      start = 1'b1;
      @(posedge clk);
      #1;
      acc = cyc;
      e.res = res;
      e.at = cyc + (zero ? ZLAT : LAT);
      e.name = name;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      dividend = {1'b0, $urandom()};
      divisor = {1'b0, $urandom()};
   endtask

   task automatic wait_dones(input int target, input string name);
      int n = 0;
      while (done_cnt < target && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (done_cnt < target) check({name, "_timeout"}, 64'(done_cnt), 64'(target));
   endtask

   task automatic run(input logic [2:0] op, input logic [PAR:0] dvd, input logic [PAR:0] dvs,
                      input logic [PAR-1:0] res, input bit zero, input string name);
      int acc;
      int target;
      target = done_cnt + 1;
      issue(op, dvd, dvs, res, zero, name, acc);
      wait_dones(target, name);
   endtask

   initial begin
      int acc;
      int target;
      exp_t e;

      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_result", 64'(result), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run(OP_DIV,  33'h1FFFFFFF9, 33'h000000002, 32'hFFFFFFFD, 1'b0, "div_m7_2");
      run(OP_REM,  33'h1FFFFFFF9, 33'h000000002, 32'hFFFFFFFF, 1'b0, "rem_m7_2");
      run(OP_DIVU, 33'h0FFFFFFFF, 33'h000000010, 32'h0FFFFFFF, 1'b0, "divu_max_16");
      run(OP_REMU, 33'h0FFFFFFFF, 33'h000000010, 32'h0000000F, 1'b0, "remu_max_16");
      run(OP_DIV,  33'h180000000, 33'h1FFFFFFFF, 32'h80000000, 1'b0, "div_overflow");
      run(OP_REM,  33'h180000000, 33'h1FFFFFFFF, 32'h00000000, 1'b0, "rem_overflow");
      run(OP_DIV,  33'h000000005, 33'h000000000, 32'hFFFFFFFF, 1'b1, "div_5_0");
      run(OP_REM,  33'h1FFFFFFF9, 33'h000000000, 32'hFFFFFFF9, 1'b1, "rem_m7_0");
      run(OP_DIV,  33'h1FFFFFFF9, 33'h000000000, 32'hFFFFFFFF, 1'b1, "div_m7_0");
      run(OP_DIVU, 33'h000000064, 33'h000000007, 32'h0000000E, 1'b0, "divu_100_7");
      run(OP_REMU, 33'h000000064, 33'h000000007, 32'h00000002, 1'b0, "remu_100_7");
      run(OP_DIV,  33'h000000064, 33'h1FFFFFFF9, 32'hFFFFFFF2, 1'b0, "div_100_m7");
      run(OP_REM,  33'h000000064, 33'h1FFFFFFF9, 32'h00000002, 1'b0, "rem_100_m7");
      run(OP_DIVU, 33'h000000003, 33'h0FFFFFFFF, 32'h00000000, 1'b0, "divu_small_big");
      run(OP_REMU, 33'h000000003, 33'h0FFFFFFFF, 32'h00000003, 1'b0, "remu_small_big");

      // start held high: second request only taken once DONE returns to IDLE
      target = done_cnt + 2;
      @(negedge clk);
      opCode = OP_DIVU;
      dividend = 33'h0FFFFFFFF;
      divisor = 33'h000000010;
      start = 1'b1;
      @(posedge clk);
      #1;
      acc = cyc;
      e.res = 32'h0FFFFFFF; e.at = acc + LAT; e.name = "hold_first";
      sb.push_back(e);
      e.res = 32'h00000002; e.at = acc + LAT + 2 + LAT; e.name = "hold_second";
      sb.push_back(e);
      @(negedge clk);
      opCode = OP_REMU;
      dividend = 33'h000000064;
      divisor = 33'h000000007;
      while (cyc < acc + LAT + 2) @(posedge clk);
      #1;
      start = 1'b0;
      wait_dones(target, "hold");

      // stray start mid-operation must not disturb the result
      target = done_cnt + 1;
      issue(OP_DIV, 33'h1FFFFFFF9, 33'h000000002, 32'hFFFFFFFD, 1'b0, "pulse", acc);
      while (cyc < acc + 9) @(posedge clk);
      @(negedge clk);
      opCode = OP_DIVU;
      dividend = 33'h000000064;
      divisor = 33'h000000003;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_dones(target, "pulse");

      // asynchronous reset mid-division
      issue(OP_DIV, 33'h000000064, 33'h000000007, 32'h0000000E, 1'b0, "aborted", acc);
      while (cyc < acc + 14) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_result", 64'(result), 64'd0);
      void'(sb.pop_back());
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(posedge clk);
      run(OP_DIV, 33'h1FFFFFFF9, 33'h000000002, 32'hFFFFFFFD, 1'b0, "after_reset");

      repeat (3) @(posedge clk);
      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
